fb_store_buffer: RTL and testbench

Write buffer between the pipeline's Memory stage and the framebuffer RAM. It captures word stores whose address falls inside the framebuffer window and queues them in a small FIFO. It drains them to the shared framebuffer write port through a req/gnt handshake, so arbitration with video scanout never stalls the core unless the queue is full. Stores outside the window are ignored here and continue to the data memory unchanged.

---
 rtl/fb_store_buffer.sv | 87 ++++++++
 tb/tb_fb_store_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_store_buffer.sv
// fb_store_buffer: captures word stores that hit the framebuffer window and
// queues them in a small FIFO, draining through a req/gnt handshake so that
// scanout arbitration only stalls the core when the queue is full.
module fb_store_buffer #(
  parameter logic [31:0] FB_BASE = 32'h0001_0000,
  parameter int          ADDR_W  = 14,
  parameter int          PIX_W   = 24,
  parameter int          DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MemWriteM,
  input  logic [31:0]                ALU_ResultM,
  input  logic [31:0]                WriteDataM,
  output logic                       StallM,
  output logic                       fb_req,
  input  logic                       fb_gnt,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [PIX_W-1:0]           fb_data,
  output logic [$clog2(DEPTH):0]     fb_pending,
  output logic                       fb_idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PIX_W-1:0]  data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic hit;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // Byte-lane bits and the pixel's upper store bits play no part here.
  logic unused_bits;
  assign unused_bits = ^{ALU_ResultM[1:0], WriteDataM[31:PIX_W]};

  // Window decode, stall and handshake qualification (Memory stage).
  assign hit   = MemWriteM && (ALU_ResultM[31:ADDR_W+2] == FB_BASE[31:ADDR_W+2]);
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = hit && !full;
  assign pop   = !empty && fb_gnt;

  assign StallM = hit && full;

  // Queue control: pointers wrap naturally, count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: data-only, never reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= ALU_ResultM[ADDR_W+1:2];
      data_mem[wr_ptr] <= WriteDataM[PIX_W-1:0];
    end
  end

  // Drain side: head entry presented from registered state, zeroed when idle.
  assign fb_req     = !empty;
  assign fb_addr    = empty ? '0 : addr_mem[rd_ptr];
  assign fb_data    = empty ? '0 : data_mem[rd_ptr];
  assign fb_pending = count;
  assign fb_idle    = empty;

endmodule

// File: tb/tb_fb_store_buffer.sv
// Bench for fb_store_buffer: queue-based reference model of the window
// decode and FIFO drain, driven with directed and randomized stores.
module tb_fb_store_buffer;

  localparam logic [31:0] FB_BASE = 32'h0001_0000;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 24;
  localparam int DEPTH  = 4;
  localparam longint WIN_BYTES = 64'd4 << ADDR_W;

  logic                  clk;
  logic                  rst;
  logic                  MemWriteM;
  logic [31:0]           ALU_ResultM;
  logic [31:0]           WriteDataM;
  logic                  StallM;
  logic                  fb_req;
  logic                  fb_gnt;
  logic [ADDR_W-1:0]     fb_addr;
  logic [PIX_W-1:0]      fb_data;
  logic [$clog2(DEPTH):0] fb_pending;
  logic                  fb_idle;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending (word address, pixel) pairs.
  logic [ADDR_W-1:0] mq_a [$];
  logic [PIX_W-1:0]  mq_d [$];

  fb_store_buffer #(
    .FB_BASE(FB_BASE), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .StallM(StallM), .fb_req(fb_req), .fb_gnt(fb_gnt),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_pending(fb_pending), .fb_idle(fb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(FB_BASE)) && (la < longint'(FB_BASE) + WIN_BYTES);
  endfunction

  function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
    longint off;
    off = (longint'(a) - longint'(FB_BASE)) / 4;
    return off[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] m_addr();
    return (mq_a.size() != 0) ? mq_a[0] : '0;
  endfunction

  function automatic logic [PIX_W-1:0] m_data();
    return (mq_d.size() != 0) ? mq_d[0] : '0;
  endfunction

  function automatic bit m_stall();
    return MemWriteM && in_win(ALU_ResultM) && (mq_a.size() == DEPTH);
  endfunction

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic g);
    @(negedge clk);
    MemWriteM   = mw;
    ALU_ResultM = a;
    WriteDataM  = d;
    fb_gnt      = g;
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit pu, po;
    pu = MemWriteM && in_win(ALU_ResultM) && (mq_a.size() < DEPTH);
    po = (mq_a.size() != 0) && fb_gnt;
    @(posedge clk);
    if (po) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (pu) begin
      mq_a.push_back(word_of(ALU_ResultM));
      mq_d.push_back(WriteDataM[PIX_W-1:0]);
    end
  endtask

  task automatic model_clear();
    mq_a.delete();
    mq_d.delete();
  endtask

  task automatic test_reset();
    MemWriteM = 0; ALU_ResultM = 0; WriteDataM = 0; fb_gnt = 0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallM); end
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", fb_req); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", fb_addr); end
    checks++; if (fb_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", fb_data); end
    checks++; if (fb_pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", fb_pending); end
    checks++; if (fb_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", fb_idle); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_store(input string tag);
    drive(1'b1, 32'h0001_0010, 32'h00AB_CDEF, 1'b1);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL %s_stall: got %b want 0", tag, StallM); end
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL %s_req0: got %b want 0", tag, fb_req); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (fb_req !== 1'b1) begin errors++; $display("FAIL %s_req1: got %b want 1", tag, fb_req); end
    checks++; if (fb_addr !== 14'd4) begin errors++; $display("FAIL %s_addr: got %0d want 4", tag, fb_addr); end
    checks++; if (fb_data !== 24'hABCDEF) begin errors++; $display("FAIL %s_data: got %h want abcdef", tag, fb_data); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL %s_req_after: got %b want 0", tag, fb_req); end
    checks++; if (fb_idle !== 1'b1) begin errors++; $display("FAIL %s_idle: got %b want 1", tag, fb_idle); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL %s_addr_after: got %h want 0", tag, fb_addr); end
  endtask

  task automatic test_outside_window();
    logic [31:0] outs [4];
    outs[0] = 32'h0000_0100;
    outs[1] = 32'h0005_0000;
    outs[2] = 32'h0000_FFFC;
    outs[3] = 32'h0002_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, outs[i], $urandom, 1'b0);
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL outside_stall[%0d]: got %b want 0", i, StallM); end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL outside_req[%0d]: got %b want 0", i, fb_req); end
      checks++; if (fb_pending !== '0) begin errors++; $display("FAIL outside_pending[%0d]: got %0d want 0", i, fb_pending); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, FB_BASE + 32'(4 * i), $urandom, 1'b0);
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL bp_stall_fill[%0d]: got %b want 0", i, StallM); end
      checks++; if (fb_pending !== 3'(i)) begin errors++; $display("FAIL bp_pending[%0d]: got %0d want %0d", i, fb_pending, i); end
      tick();
    end
    d4 = $urandom;
    drive(1'b1, FB_BASE + 32'd16, d4, 1'b0);
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL bp_stall_full: got %b want 1", StallM); end
    checks++; if (fb_pending !== 3'd4) begin errors++; $display("FAIL bp_pending_full: got %0d want 4", fb_pending); end
    tick();
    drive(1'b1, FB_BASE + 32'd16, d4, 1'b1);
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL bp_stall_gnt: got %b want 1", StallM); end
    checks++; if (fb_addr !== 14'd0) begin errors++; $display("FAIL bp_head0: got %0d want 0", fb_addr); end
    tick();
    drive(1'b1, FB_BASE + 32'd16, d4, 1'b0);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL bp_stall_release: got %b want 0", StallM); end
    checks++; if (fb_pending !== 3'd3) begin errors++; $display("FAIL bp_pending_after_pop: got %0d want 3", fb_pending); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      checks++; if (fb_addr !== 14'(k)) begin errors++; $display("FAIL bp_drain_addr[%0d]: got %0d want %0d", k, fb_addr, k); end
      checks++; if (fb_data !== m_data()) begin errors++; $display("FAIL bp_drain_data[%0d]: got %h want %h", k, fb_data, m_data()); end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (fb_idle !== 1'b1) begin errors++; $display("FAIL bp_idle: got %b want 1", fb_idle); end
  endtask

  task automatic test_simul_push_pop();
    logic [31:0] a [3];
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) begin
      a[i] = FB_BASE + (32'($urandom_range(0, (1 << ADDR_W) - 1)) << 2);
      d[i] = $urandom;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, a[i], d[i], 1'b0);
      tick();
    end
    drive(1'b1, a[2], d[2], 1'b1);
    checks++; if (fb_pending !== 3'd2) begin errors++; $display("FAIL simul_pending_before: got %0d want 2", fb_pending); end
    checks++; if (fb_addr !== word_of(a[0])) begin errors++; $display("FAIL simul_head_before: got %h want %h", fb_addr, word_of(a[0])); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (fb_pending !== 3'd2) begin errors++; $display("FAIL simul_pending[%0d]: got %0d want 2", c, fb_pending); end
      checks++; if (fb_addr !== word_of(a[1])) begin errors++; $display("FAIL simul_hold_addr[%0d]: got %h want %h", c, fb_addr, word_of(a[1])); end
      checks++; if (fb_data !== d[1][PIX_W-1:0]) begin errors++; $display("FAIL simul_hold_data[%0d]: got %h want %h", c, fb_data, d[1][PIX_W-1:0]); end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (fb_addr !== word_of(a[2]) || fb_data !== d[2][PIX_W-1:0]) begin
      errors++; $display("FAIL simul_appended: got %h/%h want %h/%h", fb_addr, fb_data, word_of(a[2]), d[2][PIX_W-1:0]);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (fb_idle !== 1'b1) begin errors++; $display("FAIL simul_idle: got %b want 1", fb_idle); end
  endtask

  task automatic test_wrap_random();
    localparam int N = 3 * DEPTH + 1;
    logic [ADDR_W-1:0] exp_a [$];
    logic [PIX_W-1:0]  exp_d [$];
    logic [ADDR_W-1:0] got_a [$];
    logic [PIX_W-1:0]  got_d [$];
    logic mw;
    logic [31:0] a, d;
    bit hold, st;
    int pushed;
    int c;
    hold = 0; pushed = 0; mw = 0; a = 0; d = 0;
    for (c = 0; c < 400 && (pushed < N || mq_a.size() != 0); c++) begin
      if (!hold) begin
        mw = (pushed < N) && ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0)
          a = 32'h0003_0000 + 32'($urandom_range(0, 255));
        else
          a = FB_BASE + (32'($urandom_range(0, (1 << ADDR_W) - 1)) << 2) + 32'($urandom_range(0, 3));
        d = $urandom;
      end
      drive(mw, a, d, c[0]);
      st = m_stall();
      checks++; if (StallM !== st) begin errors++; $display("FAIL wrap_stall[%0d]: got %b want %b", c, StallM, st); end
      checks++; if (fb_req !== (mq_a.size() != 0)) begin errors++; $display("FAIL wrap_req[%0d]: got %b want %b", c, fb_req, mq_a.size() != 0); end
      checks++; if (fb_pending !== 3'(mq_a.size())) begin errors++; $display("FAIL wrap_pending[%0d]: got %0d want %0d", c, fb_pending, mq_a.size()); end
      checks++; if (fb_addr !== m_addr() || fb_data !== m_data()) begin
        errors++; $display("FAIL wrap_head[%0d]: got %h/%h want %h/%h", c, fb_addr, fb_data, m_addr(), m_data());
      end
      if (fb_req && fb_gnt) begin
        got_a.push_back(fb_addr);
        got_d.push_back(fb_data);
      end
      if (mw && in_win(a) && !st) begin
        pushed++;
        exp_a.push_back(word_of(a));
        exp_d.push_back(d[PIX_W-1:0]);
      end
      hold = st;
      tick();
    end
    checks++; if (pushed != N || mq_a.size() != 0) begin
      errors++; $display("FAIL wrap_timeout: got pushed=%0d left=%0d want pushed=%0d left=0", pushed, mq_a.size(), N);
    end
    checks++; if (got_a.size() != exp_a.size()) begin
      errors++; $display("FAIL wrap_count: got %0d writes want %0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        checks++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL wrap_order[%0d]: got %h/%h want %h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, FB_BASE + 32'(8 * i), $urandom, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (fb_pending !== 3'd3) begin errors++; $display("FAIL rmd_pending_before: got %0d want 3", fb_pending); end
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL rmd_req: got %b want 0", fb_req); end
    checks++; if (fb_pending !== '0) begin errors++; $display("FAIL rmd_pending: got %0d want 0", fb_pending); end
    checks++; if (fb_idle !== 1'b1) begin errors++; $display("FAIL rmd_idle: got %b want 1", fb_idle); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_single_store("rmd_single");
  endtask

  initial begin
    test_reset();
    test_single_store("single");
    test_outside_window();
    test_backpressure();
    test_simul_push_pop();
    test_wrap_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
